mc_mips_ctrl: RTL and testbench
===============================

Name: mc_mips_ctrl

Overview:
Multi-cycle successor to the single-cycle controller. Sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB over a shared, variable-latency memory port using a req/ready handshake, and drives the datapath muxes, ALU and write enables. Adds a bus-timeout error path and parametrised cycle/retire performance counters. Sits between the datapath (PC, IR, regFile, alu_core, ALUOut) and a unified instruction/data memory.

Parameters:
CNT_W, 32, width of cycle_cnt and retired_cnt; both wrap modulo 2^CNT_W
MEM_TIMEOUT, 16, max cycles a memory state waits for mem_ready; 0 disables timeout
TMO_W, 5, width of the wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst_mc  in  1  asynchronous, active-low reset
instr  in  32  IR contents (valid from DECODE onward)
alu_zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
cnt_clr  in  1  synchronous clear of both counters
mem_req  out  1  memory access request
mem_we  out  1  write strobe (qualifies mem_req)
iord  out  1  memory address select: 0=PC, 1=ALUOut
ir_write  out  1  load IR from memory read data
pc_write  out  1  load PC
pc_src  out  2  00=ALU result, 01=ALUOut, 10={PC[31:28],instr[25:0],2'b00}
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  00=regB, 01=const 4, 10=sext(imm16), 11=sext(imm16)<<2
alu_op  out  2  00=add, 01=sub, 10=or, 11=lui (imm16<<16)
reg_write  out  1  regFile write enable
reg_dst  out  1  0=rt, 1=rd
mem2reg  out  1  write-back source: 1=MDR, 0=ALUOut
instr_retired  out  1  one-cycle pulse on an instruction's final cycle
illegal  out  1  one-cycle pulse on an unsupported opcode/funct in DECODE
bus_err  out  1  one-cycle pulse on memory timeout
state  out  4  current FSM state encoding
cycle_cnt  out  CNT_W  cycles since reset/clear
retired_cnt  out  CNT_W  retired instructions since reset/clear

Behaviour:
- Reset (rst_mc low, async): state=FETCH, counters=0, wait counter=0; all outputs except state are 0 while reset is asserted.
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WR=4, WB_MEM=5, EXEC_R=6, WB_R=7, EXEC_I=8, WB_I=9, BRANCH=10, JUMP=11.
- Handshake: in FETCH/MEM_RD/MEM_WR, mem_req=1 is held until a cycle where mem_ready=1; that cycle completes the access and the state advances. mem_ready outside these states is ignored.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_write=mem_ready (Mealy) -> DECODE on ready.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Opcode dispatch: 000000 with funct 100001 (addu) or 100011 (subu) -> EXEC_R; 001101 ori, 001111 lui -> EXEC_I; 100011 lw, 101011 sw -> MEM_ADDR; 000100 beq -> BRANCH; 000010 j -> JUMP; anything else -> illegal=1, FETCH (no retire).
- EXEC_R: src_a=1, src_b=00, alu_op = add/sub per funct. WB_R: reg_write=1, reg_dst=1, mem2reg=0, retire.
- EXEC_I: src_a=1, src_b=10, alu_op=10 (ori) or 11 (lui). ori zero-extension is performed by the datapath on alu_op=10. WB_I: reg_write=1, reg_dst=0, retire.
- MEM_ADDR: src_a=1, src_b=10, add -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: iord=1, mem_req=1, mem_we=0 -> WB_MEM on ready.
- MEM_WR: iord=1, mem_req=1, mem_we=1; retire on ready -> FETCH.
- WB_MEM: reg_write=1, reg_dst=0, mem2reg=1, retire.
- BRANCH: src_a=1, src_b=00, sub, pc_src=01, pc_write=alu_zero, retire -> FETCH.
- JUMP: pc_src=10, pc_write=1, retire -> FETCH.
- All non-listed outputs are 0 in each state.
- Zero-wait latencies: beq/j 3 cycles; R-type/ori/lui/sw 4 cycles; lw 5 cycles.
- Timeout (MEM_TIMEOUT>0): the wait counter increments each mem-state cycle with mem_ready=0 and clears on state exit. When it reaches MEM_TIMEOUT, bus_err pulses and the FSM goes to FETCH with no ir_write/pc_write/retire. FETCH timeout retries the same PC. A data timeout abandons the instruction; the PC is already advanced.
- Counters: cycle_cnt increments every non-reset cycle. retired_cnt increments on instr_retired. Both wrap. cnt_clr wins over a same-cycle increment, so the counter reads 0 the next cycle.

Test Plan:
- mem_ready=1; program addu/subu/ori/lui/sw/lw/beq(taken)/j -> per-instruction cycles 4,4,4,4,4,5,3,3; retired_cnt=8; cycle_cnt=31 after the last retire.
- FETCH with mem_ready low for 3 cycles -> mem_req held 4 cycles; ir_write/pc_write high only in the 4th cycle.
- MEM_TIMEOUT=4, lw with mem_ready stuck 0 -> bus_err pulse after 4 MEM_RD cycles; FETCH next; no reg_write; retired_cnt unchanged.
- beq with alu_zero=0 -> pc_write=0 in BRANCH; instr_retired=1; next state FETCH.
- opcode 0x3F -> illegal pulse in DECODE; FETCH next; no retire.
- Reset mid-MEM_WR (rst_mc low for 1 cycle) -> mem_req/mem_we drop immediately; state=FETCH; counters=0. CNT_W=4 -> cycle_cnt wraps 15->0.

Source files
------------

// File: rtl/mc_mips_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// over a shared req/ready memory port, with bus timeout and performance counters.
`timescale 1ns/1ps
module mc_mips_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic             clk,
  input  logic             rst_mc,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem2reg,
  output logic             instr_retired,
  output logic             illegal,
  output logic             bus_err,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WR   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // The wait counter hits this value on the last tolerated cycle without ready.
  localparam logic [TMO_W-1:0] TMO_LAST =
    (MEM_TIMEOUT > 0) ? TMO_W'(MEM_TIMEOUT - 1) : '0;

  state_e           r_state;
  state_e           w_next;
  logic [TMO_W-1:0] r_wait;
  logic [5:0]       w_opcode;
  logic [5:0]       w_funct;
  logic             w_mem_state;
  logic             w_timeout;

  assign w_opcode    = instr[31:26];
  assign w_funct     = instr[5:0];
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);
  assign w_timeout   = (MEM_TIMEOUT > 0) && w_mem_state && !mem_ready &&
                       (r_wait == TMO_LAST);
  assign state       = r_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_mc) begin
    if (!rst_mc) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_mc) begin
    if (!rst_mc) begin
      r_wait <= '0;
    end else if ((MEM_TIMEOUT > 0) && w_mem_state && !mem_ready && !w_timeout) begin
      r_wait <= r_wait + 1'b1;
    end else begin
      r_wait <= '0;
    end
  end

  // NOTE: every output and the next state get a default before the case so
  // no path through the block leaves a value unassigned (no latches).
  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem2reg       = 1'b0;
    instr_retired = 1'b0;
    illegal       = 1'b0;
    bus_err       = 1'b0;
    // Outputs stay quiet while reset is held, even though FETCH would request.
    if (rst_mc) begin
      unique case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_DECODE;
          end else if (w_timeout) begin
            bus_err = 1'b1;
            w_next  = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          unique case (w_opcode)
            OP_RTYPE: begin
              if (w_funct == FN_ADDU || w_funct == FN_SUBU) begin
                w_next = S_EXEC_R;
              end else begin
                illegal = 1'b1;
                w_next  = S_FETCH;
              end
            end
            OP_ORI, OP_LUI: w_next = S_EXEC_I;
            OP_LW, OP_SW:   w_next = S_MEM_ADDR;
            OP_BEQ:         w_next = S_BRANCH;
            OP_J:           w_next = S_JUMP;
            default: begin
              illegal = 1'b1;
              w_next  = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          w_next    = (w_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            w_next = S_WB_MEM;
          end else if (w_timeout) begin
            bus_err = 1'b1;
            w_next  = S_FETCH;
          end
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            instr_retired = 1'b1;
            w_next        = S_FETCH;
          end else if (w_timeout) begin
            bus_err = 1'b1;
            w_next  = S_FETCH;
          end
        end
        S_WB_MEM: begin
          reg_write     = 1'b1;
          mem2reg       = 1'b1;
          instr_retired = 1'b1;
          w_next        = S_FETCH;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = (w_funct == FN_SUBU) ? 2'b01 : 2'b00;
          w_next    = S_WB_R;
        end
        S_WB_R: begin
          reg_write     = 1'b1;
          reg_dst       = 1'b1;
          instr_retired = 1'b1;
          w_next        = S_FETCH;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = (w_opcode == OP_LUI) ? 2'b11 : 2'b10;
          w_next    = S_WB_I;
        end
        S_WB_I: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
          w_next        = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_src        = 2'b01;
          pc_write      = alu_zero;
          instr_retired = 1'b1;
          w_next        = S_FETCH;
        end
        S_JUMP: begin
          pc_src        = 2'b10;
          pc_write      = 1'b1;
          instr_retired = 1'b1;
          w_next        = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_mc) begin
    if (!rst_mc) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_retired) begin
        retired_cnt <= retired_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_mips_ctrl.sv
// Randomized bench for mc_mips_ctrl: a per-instruction phase model predicts every
// cycle's state, controls and counters; a 4-bit-counter copy checks wrap-around.
`timescale 1ns/1ps
module tb_mc_mips_ctrl;

  localparam int TMO = 4;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_write, reg_dst, mem2reg, instr_retired, illegal, bus_err;
  } ctrl_t;

  typedef struct {
    logic [3:0]  st;
    ctrl_t       c;
    logic        rdy;
    logic        zero;
    logic [31:0] ins;
  } cyc_t;

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_SW, K_LW, K_BEQ, K_J, K_ILL} kind_e;

  logic        clk = 1'b0, rst_mc = 1'b0;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0, mem_ready = 1'b0, cnt_clr = 1'b0;

  logic        mem_req, mem_we, iord, ir_write, pc_write, alu_src_a;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic        reg_write, reg_dst, mem2reg, instr_retired, illegal, bus_err;
  logic [3:0]  state;
  logic [31:0] cycle_cnt, retired_cnt;

  logic        n_mem_req, n_mem_we, n_iord, n_ir_write, n_pc_write, n_alu_src_a;
  logic [1:0]  n_pc_src, n_alu_src_b, n_alu_op;
  logic        n_reg_write, n_reg_dst, n_mem2reg, n_instr_retired, n_illegal, n_bus_err;
  logic [3:0]  n_state;
  logic [3:0]  n_cycle_cnt, n_retired_cnt;

  mc_mips_ctrl #(.CNT_W(32), .MEM_TIMEOUT(TMO), .TMO_W(5)) u_dut (
    .clk(clk), .rst_mc(rst_mc), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .cnt_clr(cnt_clr), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem2reg(mem2reg),
    .instr_retired(instr_retired), .illegal(illegal), .bus_err(bus_err),
    .state(state), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  mc_mips_ctrl #(.CNT_W(4), .MEM_TIMEOUT(TMO), .TMO_W(3)) u_dut_n (
    .clk(clk), .rst_mc(rst_mc), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .cnt_clr(cnt_clr), .mem_req(n_mem_req), .mem_we(n_mem_we),
    .iord(n_iord), .ir_write(n_ir_write), .pc_write(n_pc_write), .pc_src(n_pc_src),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
    .reg_write(n_reg_write), .reg_dst(n_reg_dst), .mem2reg(n_mem2reg),
    .instr_retired(n_instr_retired), .illegal(n_illegal), .bus_err(n_bus_err),
    .state(n_state), .cycle_cnt(n_cycle_cnt), .retired_cnt(n_retired_cnt)
  );

  always #5 clk = ~clk;

  cyc_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_ret = '0;
  bit          clr_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return $urandom_range(1, 0) == 1;
  endfunction

  function automatic ctrl_t dut_ctrl();
    ctrl_t d;
    d = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
         alu_op, reg_write, reg_dst, mem2reg, instr_retired, illegal, bus_err};
    return d;
  endfunction

  function automatic logic [31:0] enc(input kind_e k);
    logic [31:0] r;
    logic [5:0]  op;
    r = $urandom;
    case (k)
      K_ADDU: return {6'h00, r[25:6], 6'h21};
      K_SUBU: return {6'h00, r[25:6], 6'h23};
      K_ORI:  return {6'h0D, r[25:0]};
      K_LUI:  return {6'h0F, r[25:0]};
      K_SW:   return {6'h2B, r[25:0]};
      K_LW:   return {6'h23, r[25:0]};
      K_BEQ:  return {6'h04, r[25:0]};
      K_J:    return {6'h02, r[25:0]};
      default: begin
        if (rb()) begin
          while (r[5:0] == 6'h21 || r[5:0] == 6'h23) r = $urandom;
          return {6'h00, r[25:0]};
        end
        op = 6'(r[31:26]);
        while (op inside {6'h00, 6'h02, 6'h04, 6'h0D, 6'h0F, 6'h23, 6'h2B})
          op = 6'($urandom_range(63, 0));
        return {op, r[25:0]};
      end
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input ctrl_t c, input logic rdy,
                      input logic zero, input logic [31:0] ins);
    cyc_t r;
    r.st = st; r.c = c; r.rdy = rdy; r.zero = zero; r.ins = ins;
    q.push_back(r);
  endtask

  // A memory phase: 'waits' cycles without ready, then one completing cycle,
  // unless the wait reaches the timeout, which ends the phase with bus_err.
  task automatic mem_phase(input logic [3:0] st, input ctrl_t base, input ctrl_t done,
                           input int waits, input logic [31:0] ins, output bit ok);
    ctrl_t c;
    ok = 1'b1;
    for (int i = 0; i < waits; i++) begin
      c = base;
      if (i == TMO - 1) begin
        c.bus_err = 1'b1;
        push(st, c, 1'b0, rb(), ins);
        ok = 1'b0;
        return;
      end
      push(st, c, 1'b0, rb(), ins);
    end
    push(st, base | done, 1'b1, rb(), ins);
  endtask

  task automatic gen(input kind_e k, input logic [31:0] ins, input int wf, input int wd,
                     input logic zero);
    ctrl_t b, d;
    bit    ok;
    b = '0; b.mem_req = 1'b1; b.alu_src_b = 2'b01;
    d = '0; d.ir_write = 1'b1; d.pc_write = 1'b1;
    mem_phase(4'd0, b, d, wf, $urandom, ok);
    if (!ok) return;
    b = '0; b.alu_src_b = 2'b11; b.illegal = (k == K_ILL);
    push(4'd1, b, rb(), rb(), ins);
    b = '0;
    case (k)
      K_ADDU, K_SUBU: begin
        b.alu_src_a = 1'b1; b.alu_op = (k == K_SUBU) ? 2'b01 : 2'b00;
        push(4'd6, b, rb(), rb(), ins);
        b = '0; b.reg_write = 1'b1; b.reg_dst = 1'b1; b.instr_retired = 1'b1;
        push(4'd7, b, rb(), rb(), ins);
      end
      K_ORI, K_LUI: begin
        b.alu_src_a = 1'b1; b.alu_src_b = 2'b10; b.alu_op = (k == K_LUI) ? 2'b11 : 2'b10;
        push(4'd8, b, rb(), rb(), ins);
        b = '0; b.reg_write = 1'b1; b.instr_retired = 1'b1;
        push(4'd9, b, rb(), rb(), ins);
      end
      K_LW, K_SW: begin
        b.alu_src_a = 1'b1; b.alu_src_b = 2'b10;
        push(4'd2, b, rb(), rb(), ins);
        b = '0; b.mem_req = 1'b1; b.iord = 1'b1; d = '0;
        if (k == K_LW) begin
          mem_phase(4'd3, b, d, wd, ins, ok);
          if (ok) begin
            b = '0; b.reg_write = 1'b1; b.mem2reg = 1'b1; b.instr_retired = 1'b1;
            push(4'd5, b, rb(), rb(), ins);
          end
        end else begin
          b.mem_we = 1'b1; d.instr_retired = 1'b1;
          mem_phase(4'd4, b, d, wd, ins, ok);
        end
      end
      K_BEQ: begin
        b.alu_src_a = 1'b1; b.alu_op = 2'b01; b.pc_src = 2'b01;
        b.pc_write = zero; b.instr_retired = 1'b1;
        push(4'd10, b, rb(), zero, ins);
      end
      K_J: begin
        b.pc_src = 2'b10; b.pc_write = 1'b1; b.instr_retired = 1'b1;
        push(4'd11, b, rb(), rb(), ins);
      end
      default: ;
    endcase
  endtask

  // Plays up to max_cycles queued cycles; entered and left at posedge+1.
  task automatic run(input int max_cycles);
    cyc_t r;
    for (int n = 0; n < max_cycles && q.size() > 0; n++) begin
      r = q.pop_front();
      instr = r.ins; alu_zero = r.zero; mem_ready = r.rdy;
      cnt_clr = clr_en && ($urandom_range(15, 0) == 0);
      @(negedge clk);
      check($sformatf("ctrl t=%0t", $time), 64'({state, dut_ctrl()}), 64'({r.st, r.c}));
      check("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
      check("retired_cnt", 64'(retired_cnt), 64'(m_ret));
      check("cycle_cnt_n", 64'(n_cycle_cnt), 64'(m_cyc[3:0]));
      check("retired_cnt_n", 64'(n_retired_cnt), 64'(m_ret[3:0]));
      @(posedge clk);
      m_cyc = cnt_clr ? '0 : m_cyc + 32'd1;
      m_ret = cnt_clr ? '0 : m_ret + 32'(r.c.instr_retired);
      #1;
    end
    cnt_clr = 1'b0;
  endtask

  initial begin
    kind_e       k;
    int          wf, wd;
    logic [31:0] ret0;

    #1;
    check("reset_outputs", 64'({state, dut_ctrl()}), 64'd0);
    check("reset_counters", 64'({cycle_cnt, retired_cnt}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_mc = 1'b1;

    // Zero-wait program: 4,4,4,4,4,5,3,3 cycles.
    for (int i = 0; i < 8; i++) gen(kind_e'(i), enc(kind_e'(i)), 0, 0, 1'b1);
    run(1000);
    check("prog_cycle_cnt", 64'(cycle_cnt), 64'd31);
    check("prog_retired_cnt", 64'(retired_cnt), 64'd8);

    gen(K_J, enc(K_J), 3, 0, 1'b0);               // fetch stalled 3 cycles
    gen(K_BEQ, enc(K_BEQ), 0, 0, 1'b0);           // branch not taken
    gen(K_ILL, 32'hFC00_0000, 0, 0, 1'b0);        // opcode 0x3F
    gen(K_ADDU, enc(K_ADDU), 6, 0, 1'b0);         // instruction fetch timeout
    run(1000);
    ret0 = m_ret;
    gen(K_LW, enc(K_LW), 0, 9, 1'b0);             // data read timeout
    run(1000);
    check("tmo_retired_cnt", 64'(retired_cnt), 64'(ret0));

    clr_en = 1'b1;
    repeat (80) begin
      k  = kind_e'($urandom_range(8, 0));
      wf = ($urandom_range(7, 0) == 0) ? $urandom_range(6, 4) : $urandom_range(2, 0);
      wd = ($urandom_range(5, 0) == 0) ? $urandom_range(6, 3) : $urandom_range(2, 0);
      gen(k, enc(k), wf, wd, rb());
      run(1000);
    end
    clr_en = 1'b0;

    // Reset asserted in the middle of a stalled store.
    gen(K_SW, enc(K_SW), 0, 3, 1'b0);
    run(3);
    mem_ready = 1'b0;
    @(negedge clk);
    check("mem_wr_state", 64'(state), 64'd4);
    check("mem_wr_req", 64'({mem_req, mem_we}), 64'b11);
    #2 rst_mc = 1'b0;
    #1;
    check("rst_mid_outputs", 64'({state, dut_ctrl()}), 64'd0);
    check("rst_mid_counters", 64'({cycle_cnt, retired_cnt}), 64'd0);
    check("rst_mid_counters_n", 64'({n_cycle_cnt, n_retired_cnt}), 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst_mc = 1'b1;
    m_cyc = '0; m_ret = '0;

    // 16 cycles from reset: the 4-bit cycle counter wraps back to 0.
    repeat (4) gen(K_ADDU, enc(K_ADDU), 0, 0, 1'b0);
    run(1000);
    check("wrap_cycle_cnt_n", 64'(n_cycle_cnt), 64'd0);
    check("wrap_cycle_cnt", 64'(cycle_cnt), 64'd16);
    check("wrap_retired_cnt_n", 64'(n_retired_cnt), 64'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
